// File: rtl/fir_tap_sequencer.sv
// Write/read scheduler for the circular FIR sample buffer and the MAC strobes that go with it.
// Latency: write 1 clk after smpl_vld; TAPS reads from clk 2; seq_done at clk TAPS+3.
// Backpressure: none; a sample arriving while busy is dropped and ovrn latches until rst.
module fir_tap_sequencer #(
  parameter int DEPTH = 1536,
  parameter int AW    = 11,
  parameter int TAPS  = 1020,
  parameter int CW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          smpl_vld,
  input  logic [DW-1:0] smpl_in,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [DW-1:0] buf_wdata,
  output logic [AW-1:0] buf_raddr,
  output logic [CW-1:0] coeff_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          primed,
  output logic          ovrn
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

  // Wide enough to hold DEPTH and any read index without overflow.
  localparam int XW = ((AW > CW + 1) ? AW : CW + 1) + 1;
  localparam logic [CW:0]   TAPS_K = (CW + 1)'(TAPS);
  localparam logic [CW:0]   ONE_K  = (CW + 1)'(1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wptr;
  logic [CW:0]   fill;
  logic [CW:0]   k;
  logic [CW:0]   fill_inc;
  logic [XW-1:0] newest_x;
  logic [XW-1:0] k_x;
  logic [XW-1:0] raddr_x;

  // Sample count after the pending write, saturating once the filter window is full.
  always_comb begin
    fill_inc = (fill == TAPS_K) ? fill : fill + ONE_K;
  end

  // Read address for index k walking backwards from the newest sample, wrapping below 0.
  // buf_waddr holds the newest write address for the whole sequence.
  always_comb begin
    newest_x = XW'(buf_waddr);
    k_x      = XW'(k);
    if (k_x > newest_x) begin
      raddr_x = newest_x + XW'(DEPTH) - k_x;
    end else begin
      raddr_x = newest_x - k_x;
    end
  end

  // Sequencer FSM: owns pointers, fill level and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      fill       <= '0;
      k          <= '0;
      buf_we     <= 1'b0;
      buf_waddr  <= '0;
      buf_wdata  <= '0;
      buf_raddr  <= '0;
      coeff_addr <= '0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      primed     <= 1'b0;
      ovrn       <= 1'b0;
    end else begin
      buf_we   <= 1'b0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      seq_done <= 1'b0;

      // Anything offered outside IDLE is lost; remember that it happened.
      if (smpl_vld && (state != IDLE)) begin
        ovrn <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (smpl_vld) begin
            buf_we    <= 1'b1;
            buf_waddr <= wptr;
            buf_wdata <= smpl_in;
            seq_busy  <= 1'b1;
            state     <= WRITE;
          end
        end

        WRITE: begin
          wptr   <= (wptr == LAST) ? '0 : wptr + 1'b1;
          fill   <= fill_inc;
          primed <= (fill_inc == TAPS_K);
          if (fill_inc == TAPS_K) begin
            buf_raddr  <= buf_waddr;
            coeff_addr <= '0;
            k          <= ONE_K;
            state      <= READ;
          end else begin
            seq_busy <= 1'b0;
            state    <= IDLE;
          end
        end

        READ: begin
          // The buffer answers one clock after each read issue, so the MAC strobe trails by one.
          mac_en  <= 1'b1;
          mac_clr <= (k == ONE_K);
          if (k == TAPS_K) begin
            state <= FLUSH;
          end else begin
            buf_raddr  <= AW'(raddr_x);
            coeff_addr <= CW'(k);
            k          <= k + ONE_K;
          end
        end

        FLUSH: begin
          seq_done <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          seq_busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          seq_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: three configurations (8/4, 1536/1020, 1536/3) side by side.
// A per-sample timeline model plus buffer/ROM/accumulator model checks every cycle.
// Directed sequences pin write/read addresses, strobe counts and latencies with literals.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld   [3];
  logic [15:0] din   [3];
  logic        we    [3];
  logic        mac_en[3];
  logic        mac_clr[3];
  logic        busy  [3];
  logic        done  [3];
  logic        primed[3];
  logic        ovrn  [3];
  logic [31:0] waddr [3];
  logic [31:0] raddr [3];
  logic [31:0] coeff [3];
  logic [15:0] wdata [3];

  function automatic int dp(input int i);
    return (i == 0) ? 8 : 1536;
  endfunction

  function automatic int tp(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1020 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D   = (g == 0) ? 8 : 1536;
    localparam int T   = (g == 0) ? 4 : ((g == 1) ? 1020 : 3);
    localparam int AWG = (g == 0) ? 3 : 11;
    localparam int CWG = (g == 1) ? 10 : 2;
    logic [AWG-1:0] wa;
    logic [AWG-1:0] ra;
    logic [CWG-1:0] ca;
    fir_tap_sequencer #(.DEPTH(D), .AW(AWG), .TAPS(T), .CW(CWG), .DW(16)) u_dut (
      .clk(clk), .rst(rst), .smpl_vld(vld[g]), .smpl_in(din[g]),
      .buf_we(we[g]), .buf_waddr(wa), .buf_wdata(wdata[g]), .buf_raddr(ra),
      .coeff_addr(ca), .mac_en(mac_en[g]), .mac_clr(mac_clr[g]), .seq_busy(busy[g]),
      .seq_done(done[g]), .primed(primed[g]), .ovrn(ovrn[g])
    );
    assign waddr[g] = 32'(wa);
    assign raddr[g] = 32'(ra);
    assign coeff[g] = 32'(ca);
  end

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int coef(input int k);
    return ((k * 37 + 11) % 201) - 100;
  endfunction

  // ---------------- timeline model ----------------
  // Each accepted sample at edge a defines cycle r = edge - a + 1 (r=1 is the write cycle).
  int     ecnt = 0;
  int     a_e  [3];
  bit     rd_m [3];
  int     wa_m [3];
  int     cnt_m[3];
  bit     ov_m [3];
  int     hist [3][0:2047];
  int     mem  [3][0:1535];
  int     pr   [3];
  int     pc   [3];
  longint acc  [3];

  function automatic bit busy_at(input int i, input int e);
    int r;
    if (a_e[i] < 0) return 1'b0;
    r = e - a_e[i] + 1;
    return (r == 1) || (rd_m[i] && r >= 1 && r <= tp(i) + 3);
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_e[i] = -1; rd_m[i] = 0; wa_m[i] = 0; cnt_m[i] = 0; ov_m[i] = 0;
      pr[i] = 0; pc[i] = 0; acc[i] = 0;
    end
  end

  // Acceptance model: a sample is taken only when the previous cycle was idle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        a_e[i] = -1; rd_m[i] = 0; cnt_m[i] = 0; ov_m[i] = 0;
      end else if (vld[i]) begin
        if (busy_at(i, ecnt)) begin
          ov_m[i] = 1;
        end else begin
          a_e[i]  = ecnt + 1;
          wa_m[i] = cnt_m[i] % dp(i);
          if (cnt_m[i] < 2048) hist[i][cnt_m[i]] = int'(din[i]);
          cnt_m[i]++;
          rd_m[i] = (cnt_m[i] >= tp(i));
        end
      end
    end
    ecnt++;
  end

  // Compare process: every cycle, every instance.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        int     r, t, d, wa, kk;
        bit     rd;
        longint p, g;
        t  = tp(i);
        d  = dp(i);
        rd = rd_m[i] && (a_e[i] >= 0);
        r  = (a_e[i] < 0) ? 0 : ecnt - a_e[i] + 1;

        // Buffer (1-clk read) + coefficient ROM + accumulator driven by the DUT strobes.
        if (mac_en[i]) begin
          p = longint'(mem[i][pr[i]]) * longint'(coef(pc[i]));
          acc[i] = mac_clr[i] ? p : acc[i] + p;
        end
        wa = int'(waddr[i]);
        if (we[i] && wa < 1536) mem[i][wa] = int'(wdata[i]);
        pr[i] = (int'(raddr[i]) < 1536) ? int'(raddr[i]) : 0;
        pc[i] = (int'(coeff[i]) < 1024) ? int'(coeff[i]) : 0;

        chk("buf_we", longint'(we[i]), longint'(r == 1));
        if (r == 1) begin
          chk("buf_waddr", longint'(waddr[i]), longint'(wa_m[i]));
          chk("buf_wdata", longint'(wdata[i]), longint'(hist[i][cnt_m[i] - 1]));
        end
        chk("seq_busy", longint'(busy[i]), longint'(busy_at(i, ecnt)));
        chk("mac_en", longint'(mac_en[i]), longint'(rd && r >= 3 && r <= t + 2));
        chk("mac_clr", longint'(mac_clr[i]), longint'(rd && r == 3));
        chk("seq_done", longint'(done[i]), longint'(rd && r == t + 3));
        chk("ovrn", longint'(ovrn[i]), longint'(ov_m[i]));
        if (r != 1) chk("primed", longint'(primed[i]), longint'(cnt_m[i] >= t));
        if (rd && r >= 2 && r <= t + 1) begin
          kk = r - 2;
          chk("buf_raddr", longint'(raddr[i]), longint'((wa_m[i] - kk + d) % d));
          chk("coeff_addr", longint'(coeff[i]), longint'(kk));
        end
        if (rd && r == t + 3) begin
          g = 0;
          for (int k = 0; k < t; k++)
            g += longint'(coef(k)) * longint'(hist[i][cnt_m[i] - 1 - k]);
          chk("fir_result", acc[i], g);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic longint outs_or(input int i);
    return longint'(we[i]) | longint'(mac_en[i]) | longint'(mac_clr[i]) | longint'(busy[i]) |
           longint'(done[i]) | longint'(primed[i]) | longint'(ovrn[i]) | longint'(waddr[i]) |
           longint'(raddr[i]) | longint'(coeff[i]) | longint'(wdata[i]);
  endfunction

  task automatic wait_idle(input int i);
    int c = 0;
    while (busy[i] && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (busy[i]) chk("idle_timeout", 1, 0);
  endtask

  task automatic send(input int i, input int data);
    @(negedge clk); vld[i] = 1'b1; din[i] = 16'(data);
    @(negedge clk); vld[i] = 1'b0;
    wait_idle(i);
  endtask

  // Instance 0 sequence with literal expectations (TAPS=4: done at cycle 7).
  task automatic lit_seq(input int data, input int exp_wa, input bit exp_rd,
                         input logic [3:0][2:0] er);
    int nmac = 0;
    int ndone = 0;
    int c = 1;
    @(negedge clk); vld[0] = 1'b1; din[0] = 16'(data);
    @(negedge clk); vld[0] = 1'b0;
    chk("lit_we", longint'(we[0]), 1);
    chk("lit_waddr", longint'(waddr[0]), longint'(exp_wa));
    chk("lit_wdata", longint'(wdata[0]), longint'(data));
    while (busy[0] && c < 50) begin
      @(negedge clk);
      c++;
      if (c == 2) chk("lit_primed", longint'(primed[0]), longint'(exp_rd));
      if (exp_rd && c >= 2 && c <= 5) chk("lit_raddr", longint'(raddr[0]), longint'(er[5 - c]));
      if (exp_rd && c == 3) chk("lit_mac_clr", longint'(mac_clr[0]), 1);
      if (mac_en[0]) nmac++;
      if (done[0]) begin
        ndone++;
        chk("lit_done_cycle", longint'(c), 7);
      end
    end
    chk("lit_mac_count", longint'(nmac), exp_rd ? 4 : 0);
    chk("lit_done_count", longint'(ndone), exp_rd ? 1 : 0);
  endtask

  task automatic full_seq(input int i, input int data, input int exp_mac, input int exp_done);
    int nmac = 0;
    int dcyc = -1;
    int c = 1;
    @(negedge clk); vld[i] = 1'b1; din[i] = 16'(data);
    @(negedge clk); vld[i] = 1'b0;
    while (busy[i] && c < 3000) begin
      if (mac_en[i]) nmac++;
      if (done[i]) dcyc = c;
      @(negedge clk);
      c++;
    end
    chk("mac_en_count", longint'(nmac), longint'(exp_mac));
    chk("done_cycle", longint'(dcyc), longint'(exp_done));
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][2:0] e;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      din[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_outputs", outs_or(i), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three samples, buffer not yet primed.
    lit_seq(16'h1111, 0, 1'b0, '0);
    lit_seq(16'h2222, 1, 1'b0, '0);
    lit_seq(16'h3333, 2, 1'b0, '0);
    // 2: fourth sample primes the filter.
    lit_seq(16'h4444, 3, 1'b1, {3'd3, 3'd2, 3'd1, 3'd0});
    // 3: samples 5..8 then wrap on the 9th.
    for (int s = 5; s <= 8; s++) begin
      for (int j = 0; j < 4; j++) e[3 - j] = 3'((s - 1 - j + 8) % 8);
      lit_seq(s * 257, s - 1, 1'b1, e);
    end
    lit_seq(16'h9999, 0, 1'b1, {3'd0, 3'd7, 3'd6, 3'd5});

    // 4: samples offered during READ and during DONE are dropped.
    @(negedge clk); vld[0] = 1'b1; din[0] = 16'hA0A0;
    @(negedge clk); vld[0] = 1'b0;
    @(negedge clk); vld[0] = 1'b1; din[0] = 16'hDEAD;
    @(negedge clk); vld[0] = 1'b0;
    chk("ovrn_after_read_drop", longint'(ovrn[0]), 1);
    repeat (4) @(negedge clk);
    chk("in_done_cycle", longint'(done[0]), 1);
    vld[0] = 1'b1; din[0] = 16'hBEEF;
    @(negedge clk); vld[0] = 1'b0;
    chk("ovrn_sticky", longint'(ovrn[0]), 1);
    wait_idle(0);
    lit_seq(16'h0B0B, 2, 1'b1, {3'd2, 3'd1, 3'd0, 3'd7});

    // 5: asynchronous reset in the middle of a READ.
    @(negedge clk); vld[0] = 1'b1; din[0] = 16'h5555;
    @(negedge clk); vld[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("async_reset_outputs", outs_or(i), 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    lit_seq(16'h6666, 0, 1'b0, '0);

    // 6: default configuration, random data against the golden FIR.
    for (int s = 0; s < 1019; s++) send(1, $urandom_range(0, 65535));
    for (int s = 0; s < 25; s++) full_seq(1, $urandom_range(0, 65535), 1020, 1023);

    // Full-depth wrap with a short filter.
    for (int s = 0; s < 1600; s++) send(2, $urandom_range(0, 65535));
    for (int s = 0; s < 4; s++) full_seq(2, $urandom_range(0, 65535), 3, 6);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
